// File: rtl/io_port_pkg.sv
// io_port_pkg: definitions shared by the I/O port bridge and its input FIFO.
//   IO_WIDTH    - width of every byte lane (processor ports, producer and consumer)
//   int_state_t - encoding of the interrupt request state machine
package io_port_pkg;

  localparam int IO_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } int_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// io_sync_fifo: single-clock FIFO with a combinational head read.
//   clk, rst       - clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata    - write request and data; ignored while full
//   pop            - read request; ignored while empty
//   rdata          - head entry, all zeros while empty
//   full, empty    - occupancy flags, decoded from the count register
//   count          - current occupancy, 0..DEPTH
module io_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  // A push while full is refused even if a pop frees a slot this cycle, so
  // the producer's ready never depends on the processor's read strobe.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr_reg];

  // Storage carries no reset: stale entries are hidden by the empty gate.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/io_port_bridge.sv
// io_port_bridge: external-side partner of the processor's I/O ports.
//   clk, rst               - clock, asynchronous active-high reset
//   src_data/valid/ready   - external producer into the input FIFO
//   in_port, in_rd         - FIFO head to processor In_port, pop strobe on IN
//   int_req                - interrupt request, INT_LEN cycles per queued byte
//   out_port, out_wr       - processor Out_port byte and OUT strobe
//   sink_data/valid/ready  - one-entry output buffer drained by a consumer
//   out_ovf                - sticky flag: an OUT byte was dropped
//   fifo_count             - input FIFO occupancy
module io_port_bridge
  import io_port_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int INT_LEN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IO_WIDTH-1:0]     src_data,
  input  logic                    src_valid,
  output logic                    src_ready,
  output logic [IO_WIDTH-1:0]     in_port,
  input  logic                    in_rd,
  output logic                    int_req,
  input  logic [IO_WIDTH-1:0]     out_port,
  input  logic                    out_wr,
  output logic [IO_WIDTH-1:0]     sink_data,
  output logic                    sink_valid,
  input  logic                    sink_ready,
  output logic                    out_ovf,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  logic       fifo_full;
  logic       fifo_empty;
  int_state_t state_reg;
  logic [3:0] cnt_reg;

  assign src_ready = !fifo_full;

  io_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (IO_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (src_valid),
    .wdata (src_data),
    .pop   (in_rd),
    .rdata (in_port),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // One request per queued byte: REQ holds int_req for INT_LEN cycles, WAIT
  // parks until the processor reads, and IDLE re-examines the post-pop FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      int_req   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_reg <= ST_REQ;
            cnt_reg   <= 4'(INT_LEN - 1);
            int_req   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (in_rd) begin
            state_reg <= ST_IDLE;
            int_req   <= 1'b0;
          end else if (cnt_reg == '0) begin
            state_reg <= ST_WAIT;
            int_req   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_WAIT: begin
          int_req <= 1'b0;
          if (in_rd) state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          int_req   <= 1'b0;
        end
      endcase
    end
  end

  // Output buffer: a new byte is accepted whenever the slot is free or is
  // being drained this same cycle; otherwise it is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sink_data  <= '0;
      sink_valid <= 1'b0;
      out_ovf    <= 1'b0;
    end else begin
      if (out_wr) begin
        if (!sink_valid || sink_ready) begin
          sink_data  <= out_port;
          sink_valid <= 1'b1;
        end else begin
          out_ovf <= 1'b1;
        end
      end else if (sink_valid && sink_ready) begin
        sink_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
- External-side partner of the processor's I/O ports. Buffers bytes from an external producer into a small FIFO, presents the head byte on the processor's In_port and raises `int` to request service.
- Captures bytes the processor writes on Out_port into a one-entry output buffer. An external consumer drains that buffer with a valid/ready handshake.
- Instantiated beside `top`. Lets the benches stream datasets such as a get-max input list and collect results without poking memory.

Parameters:
- DEPTH, 4, input FIFO entries (power of 2, at least 2).
- INT_LEN, 2, cycles `int_req` stays high per request (1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- src_data  in  8  byte from external producer
- src_valid  in  1  producer has a byte
- src_ready  out  1  bridge accepts a byte (= !full, combinational)
- in_port  out  8  to processor In_port: FIFO head, 8'h00 when empty
- in_rd  in  1  one-cycle strobe, processor executed IN (pop)
- int_req  out  1  to processor int
- out_port  in  8  from processor Out_port
- out_wr  in  1  one-cycle strobe, processor executed OUT
- sink_data  out  8  captured output byte
- sink_valid  out  1  sink_data holds an unconsumed byte
- sink_ready  in  1  consumer accepts sink_data
- out_ovf  out  1  sticky: an OUT byte was dropped
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; fifo_count=0, src_ready=1, in_port=8'h00.
  - int_req=0, FSM=IDLE, counter=0.
  - sink_data=8'h00, sink_valid=0, out_ovf=0.
  - A reset mid-operation discards FIFO contents and aborts any int pulse immediately.
- Push: src_valid && src_ready at a clk edge writes src_data at the write pointer. Pointers wrap modulo DEPTH.
- Pop: in_rd && !empty advances the read pointer. in_rd while empty is ignored: no count change, no underflow.
- Push and pop in the same cycle:
  - Non-empty: count unchanged, head advances.
  - Full: src_ready=0, so the push is not taken even though a pop frees a slot. No combinational path from in_rd to src_ready.
  - Empty: the push is taken and the pop is ignored.
- in_port is combinational from the head entry and updates the cycle after a pop or first push.
- Interrupt FSM, registered, 4-bit counter:
  - IDLE: if !empty, go to REQ with counter=INT_LEN-1 and int_req=1 from the next cycle.
  - REQ: int_req=1. If in_rd, go to IDLE. Else if counter==0, go to WAIT. Else decrement the counter.
  - WAIT: int_req=0. On in_rd, go to IDLE. A new request fires only if the FIFO is still non-empty after the pop.
  - Result: exactly one request per byte. The minimum gap between requests is 1 cycle (IDLE).
- Output buffer:
  - out_wr with !sink_valid: sink_data<=out_port, sink_valid<=1 next cycle.
  - out_wr with sink_valid && sink_ready: the old byte is consumed and the new one is loaded. sink_valid stays 1.
  - out_wr with sink_valid && !sink_ready: the new byte is dropped, sink_data is unchanged, and out_ovf<=1 (held until reset).
  - sink_valid && sink_ready without out_wr: sink_valid<=0 and sink_data holds its value.
- All outputs are registered except src_ready and in_port, which are combinational from state.

Decomposition:
- Package `io_port_pkg`:
  - Interrupt FSM state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2).
  - The IO_WIDTH=8 constant.
- Sub-module `io_sync_fifo`: DEPTH/width parameters, push/pop/full/empty/count.
- The FSM and output buffer stay in the top-level bridge.

Test Plan:
- Reset mid-stream: push 3 bytes, assert rst during an int pulse -> fifo_count=0, int_req=0 within the same cycle, src_ready=1, in_port=8'h00.
- Stream and pop: push 0x0C,0x2D,0x17,0x43,0x22 with DEPTH=4 -> the 5th push stalls (src_ready=0, fifo_count=4). Popping via in_rd after each int_req yields in_port 0x0C,0x2D,0x17,0x43,0x22 in order, one int_req pulse of INT_LEN=2 cycles per byte.
- Empty pop: in_rd with an empty FIFO -> fifo_count stays 0, in_port=8'h00, int_req stays 0.
- Full simultaneous push/pop: FIFO full, src_valid=1 and in_rd=1 in the same cycle -> fifo_count=3, the pushed byte is not written.
- Output capture: out_wr with out_port=0x43, sink_ready=0 -> next cycle sink_data=0x43, sink_valid=1. A second out_wr with 0x7F while stalled -> sink_data=0x43, out_ovf=1. Raising sink_ready -> sink_valid=0 next cycle, out_ovf still 1.
- Back-to-back output: sink_ready=1 held, out_wr with 0x11 then 0x22 in consecutive cycles -> sink_data=0x11 then 0x22, sink_valid=1 throughout, out_ovf=0.
